// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the load/store path: data width, funct3
// size/sign encodings and the LSU state type.
package riscv_pkg;

  localparam int XLEN = 32;

  // funct3[1:0] selects access size, funct3[2] selects zero-extension on loads
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUSY = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it
// according to the load funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane_s;

  assign lane_s = rdata >> {addr, 3'b000};

  // lane extension by load type
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{lane_s[7]}}, lane_s[7:0]};
      F3_LH:   data = {{16{lane_s[15]}}, lane_s[15:0]};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'h000000, lane_s[7:0]};
      F3_LHU:  data = {16'h0000, lane_s[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: captures one request, drives a simple
// ready-handshake bus, and returns extended load data or an alignment fault.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            resp_misaligned,
  output logic            stall
);

  lsu_state_t      state_r;
  logic            we_r;
  logic [XLEN-1:0] addr_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] wdata_r;
  logic [3:0]      be_r;
  logic            kill_r;
  logic [XLEN-1:0] resp_data_r;
  logic [4:0]      resp_rd_r;
  logic            misal_r;

  logic            misal_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] ext_s;

  // request decode: alignment, byte enables and lane-replicated store data
  always_comb begin
    misal_s = 1'b0;
    be_s    = 4'b0000;
    wdata_s = req_wdata;
    case (req_funct3[1:0])
      SIZE_BYTE: begin
        be_s    = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        misal_s = req_addr[0];
        be_s    = 4'b0011 << req_addr[1:0];
        wdata_s = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        misal_s = (req_addr[1:0] != 2'b00);
        be_s    = 4'b1111;
      end
      default: begin
        misal_s = 1'b0;
        be_s    = 4'b0000;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .addr   (addr_r[1:0]),
    .funct3 (funct3_r),
    .data   (ext_s)
  );

  // FSM and request/response capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= LSU_IDLE;
      we_r        <= 1'b0;
      addr_r      <= '0;
      funct3_r    <= 3'b000;
      wdata_r     <= '0;
      be_r        <= 4'b0000;
      kill_r      <= 1'b0;
      resp_data_r <= '0;
      resp_rd_r   <= 5'd0;
      misal_r     <= 1'b0;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (req_valid && !flush) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            funct3_r    <= req_funct3;
            wdata_r     <= wdata_s;
            be_r        <= be_s;
            kill_r      <= 1'b0;
            resp_data_r <= '0;
            resp_rd_r   <= req_we ? 5'd0 : req_rd;
            misal_r     <= misal_s;
            state_r     <= misal_s ? LSU_DONE : LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          // a flush cannot abort the bus transfer, only its writeback
          if (flush) kill_r <= 1'b1;
          if (mem_ready) begin
            resp_data_r <= we_r ? '0 : ext_s;
            state_r     <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          kill_r  <= 1'b0;
          state_r <= LSU_IDLE;
        end
        default: state_r <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready       = (state_r == LSU_IDLE);
  assign stall           = (state_r != LSU_IDLE);
  assign mem_req         = (state_r == LSU_BUSY);
  assign mem_we          = (state_r == LSU_BUSY) && we_r;
  assign mem_addr        = {addr_r[XLEN-1:2], 2'b00};
  assign mem_be          = be_r;
  assign mem_wdata       = wdata_r;
  assign resp_valid      = (state_r == LSU_DONE) && !kill_r && !flush;
  assign resp_data       = resp_data_r;
  assign resp_rd         = resp_rd_r;
  assign resp_misaligned = misal_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 is supported.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  execute stage presents a memory op.
REQ-006 req_ready  out  1  unit can accept; high only in IDLE.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-009 req_addr  in  32  effective address (ALU result).
REQ-010 req_wdata  in  32  store data (rs2), right-aligned.
REQ-011 req_rd  in  5  load destination register.
REQ-012 flush  in  1  kill in-flight op's writeback.
REQ-013 mem_req, mem_we  out  1,1  bus request / write strobe.
REQ-014 mem_addr  out  32  word address; bits [1:0] are 00.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_wdata  out  32  lane-replicated store data.
REQ-017 mem_ready  in  1  bus completes the transfer this cycle.
REQ-018 mem_rdata  in  32  read word, valid when mem_ready is high.
REQ-019 resp_valid  out  1  one-cycle completion pulse.
REQ-020 resp_data, resp_rd, resp_misaligned  out  32,5,1  extended load data, destination, alignment fault.
REQ-021 stall  out  1  high whenever state is not IDLE.

Function
REQ-022 States: IDLE, BUSY, DONE.
REQ-023 IDLE: on req_valid with flush low, capture all request fields; aligned -> BUSY; misaligned -> DONE with misaligned=1 and no bus access.
REQ-024 Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-025 BUSY: mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held stable until mem_ready; on mem_ready -> DONE, latching the extended read data.
REQ-026 DONE: resp_valid=1 for exactly one cycle, then -> IDLE; req_ready=0 while in DONE.
REQ-027 Latency: accept at edge N; mem_req high from N+1; if mem_ready first arrives in cycle M, resp_valid is high in cycle M+1.
REQ-028 mem_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-029 mem_wdata: byte {4{b}}, half {2{h}}, word as-is.
REQ-030 Loads: select the lane by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-031 For stores, resp_data=0 and resp_rd=0.
REQ-032 flush in BUSY: the bus transfer still completes (no abort); resp_valid is suppressed for that op.
REQ-033 flush in DONE: resp_valid is suppressed.
REQ-034 flush in IDLE: any request that cycle is ignored.
REQ-035 req_valid outside IDLE is ignored; the upstream stage holds via stall.

Reset
REQ-036 On reset: state=IDLE; mem_req, mem_we, resp_valid, resp_misaligned, stall = 0; mem_be=0000; mem_addr, mem_wdata, resp_data, resp_rd = 0.
REQ-037 Reset during BUSY drops mem_req at the next edge; no resp_valid is produced for that op.

Structure
REQ-038 Shared package riscv_pkg holds: the funct3 width/sign encodings, the lsu_state_t enum, and the XLEN constant.
REQ-039 Sub-module load_extend (combinational): inputs rdata, addr[1:0], funct3; output 32-bit extended data.

Verification
REQ-040 LW addr 0x100, mem_ready same cycle as mem_req, rdata 0xDEADBEEF -> mem_be 1111, resp_data 0xDEADBEEF at accept+2.
REQ-041 LB addr 0x103, rdata 0x80FF_0000 -> resp_data 0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-042 SH addr 0x22, wdata 0x0000ABCD -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCDABCD, mem_we=1.
REQ-043 LW addr 0x102 -> no mem_req; resp_valid with resp_misaligned=1 at accept+1.
REQ-044 LH with mem_ready delayed 5 cycles, flush pulsed in cycle 2 -> signals stable throughout, stall high, no resp_valid.
REQ-045 Reset asserted mid-BUSY -> all outputs at reset values next cycle; state IDLE; req_ready=1.
